// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB pipeline register.
// Optional forwarding outputs are enabled by MEM_WB_FWD_EN.
package mem_wb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     result;
    logic [DATA_W_DEF-1:0]     read_data;
    logic                      mem_to_reg;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      reg_write;
  } mem_wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

endpackage

// File: rtl/mem_wb_pipe_reg_skid_slot.sv
// One-entry holding register with its own valid bit.
// Used for both the main and the skid slot.
module skid_slot
  import mem_wb_pkg::*;
#(
  parameter type T = mem_wb_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  T     d,
  output T     q,
  output logic valid
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB register with a two-entry skid buffer and valid/ready handshake.
// Define MEM_WB_FWD_EN to add the EX forwarding outputs.
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_in_mem_wb,
  input  logic                  valid_in_mem_wb,
  output logic                  ready_out_mem_wb,
  input  logic [DATA_W-1:0]     result_in_mem_wb,
  input  logic [DATA_W-1:0]     read_data_in_mem_wb,
  input  logic                  mem_to_reg_in_mem_wb,
  input  logic [REG_ADDR_W-1:0] rd_in_mem_wb,
  input  logic                  reg_write_in_mem_wb,
`ifdef MEM_WB_FWD_EN
  output logic                  fwd_valid_mem_wb,
  output logic [REG_ADDR_W-1:0] fwd_rd_mem_wb,
  output logic [DATA_W-1:0]     fwd_data_mem_wb,
`endif
  output logic                  valid_out_mem_wb,
  input  logic                  ready_in_mem_wb,
  output logic [DATA_W-1:0]     result_out_mem_wb,
  output logic [DATA_W-1:0]     read_data_out_mem_wb,
  output logic                  mem_to_reg_out_mem_wb,
  output logic [REG_ADDR_W-1:0] rd_out_mem_wb,
  output logic                  reg_write_out_mem_wb
);

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     read_data;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } entry_t;

  state_t state_q, state_d;
  entry_t in_e, main_d, main_q, skid_q;
  logic   main_vld, skid_vld;
  logic   load_main, load_skid;
  logic   clr_main, clr_skid;
  logic   accept, consume;
  logic   rd_zero;

  assign in_e = '{
    result:     result_in_mem_wb,
    read_data:  read_data_in_mem_wb,
    mem_to_reg: mem_to_reg_in_mem_wb,
    rd:         rd_in_mem_wb,
    reg_write:  reg_write_in_mem_wb
  };

  assign accept  = valid_in_mem_wb & ready_out_mem_wb;
  assign consume = main_vld & ready_in_mem_wb;

  // Draining the skid slot refills main from it; otherwise from MEM.
  assign main_d = (state_q == TWO) ? skid_q : in_e;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= EMPTY;
      ready_out_mem_wb <= 1'b0;
    end else begin
      state_q          <= state_d;
      ready_out_mem_wb <= (state_d != TWO);
    end
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    clr_main  = 1'b0;
    clr_skid  = 1'b0;
    if (flush_in_mem_wb) begin
      state_d  = EMPTY;
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end else if (consume) begin
            clr_main = 1'b1;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            load_main = 1'b1;
            clr_skid  = 1'b1;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  skid_slot #(.T(entry_t)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (load_main),
    .clear (clr_main),
    .d     (main_d),
    .q     (main_q),
    .valid (main_vld)
  );

  skid_slot #(.T(entry_t)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (load_skid),
    .clear (clr_skid),
    .d     (in_e),
    .q     (skid_q),
    .valid (skid_vld)
  );

  assign rd_zero = ZERO_REG_SUPPRESS && (main_q.rd == '0);

  assign valid_out_mem_wb      = main_vld;
  assign result_out_mem_wb     = main_q.result;
  assign read_data_out_mem_wb  = main_q.read_data;
  assign mem_to_reg_out_mem_wb = main_q.mem_to_reg;
  assign rd_out_mem_wb         = main_q.rd;
  assign reg_write_out_mem_wb  = main_vld & main_q.reg_write & ~rd_zero;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid_mem_wb = reg_write_out_mem_wb;
  assign fwd_rd_mem_wb    = main_q.rd;
  assign fwd_data_mem_wb  = main_q.mem_to_reg ? main_q.read_data
                                              : main_q.result;
`else
  logic unused_skid_vld;
  assign unused_skid_vld = skid_vld;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Randomised bench for mem_wb_pipe_reg against a queue-based model,
// plus directed checks of reset, back-pressure, flush and x0 handling.
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] result_in;
  logic [31:0] rdata_in;
  logic        m2r_in;
  logic [4:0]  rd_in;
  logic        rw_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result_out;
  logic [31:0] rdata_out;
  logic        m2r_out;
  logic [4:0]  rd_out;
  logic        rw_out;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  mem_wb_pipe_reg dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_in_mem_wb       (flush),
    .valid_in_mem_wb       (valid_in),
    .ready_out_mem_wb      (ready_out),
    .result_in_mem_wb      (result_in),
    .read_data_in_mem_wb   (rdata_in),
    .mem_to_reg_in_mem_wb  (m2r_in),
    .rd_in_mem_wb          (rd_in),
    .reg_write_in_mem_wb   (rw_in),
`ifdef MEM_WB_FWD_EN
    .fwd_valid_mem_wb      (fwd_valid),
    .fwd_rd_mem_wb         (fwd_rd),
    .fwd_data_mem_wb       (fwd_data),
`endif
    .valid_out_mem_wb      (valid_out),
    .ready_in_mem_wb       (ready_in),
    .result_out_mem_wb     (result_out),
    .read_data_out_mem_wb  (rdata_out),
    .mem_to_reg_out_mem_wb (m2r_out),
    .rd_out_mem_wb         (rd_out),
    .reg_write_out_mem_wb  (rw_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rdat;
    logic        m2r;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;

  ent_t q[$];
  bit   mready  = 1'b0;
  bit   started = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a FIFO of at most two entries; ready reflects free space.
  always @(posedge clk) begin
    bit   acc, con;
    ent_t e;
    started = 1'b1;
    if (!rst) begin
      q.delete();
      mready = 1'b0;
    end else if (flush) begin
      q.delete();
      mready = 1'b1;
    end else begin
      acc = valid_in && mready;
      con = (q.size() > 0) && ready_in;
      e   = '{result_in, rdata_in, m2r_in, rd_in, rw_in};
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
      mready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    bit exp_rw;
    if (started) begin
      chk("ready_out", ready_out, mready);
      chk("valid_out", valid_out, q.size() > 0);
      exp_rw = (q.size() > 0) && q[0].rw && (q[0].rd != 0);
      chk("reg_write_out", rw_out, exp_rw);
`ifdef MEM_WB_FWD_EN
      chk("fwd_valid", fwd_valid, exp_rw);
`endif
      if (q.size() > 0) begin
        chk("result_out", result_out, q[0].res);
        chk("read_data_out", rdata_out, q[0].rdat);
        chk("mem_to_reg_out", m2r_out, q[0].m2r);
        chk("rd_out", rd_out, q[0].rd);
`ifdef MEM_WB_FWD_EN
        chk("fwd_rd", fwd_rd, q[0].rd);
        chk("fwd_data", fwd_data, q[0].m2r ? q[0].rdat : q[0].res);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] r, logic [31:0] d,
                       bit m, logic [4:0] a, bit w);
    valid_in  = v;
    result_in = r;
    rdata_in  = d;
    m2r_in    = m;
    rd_in     = a;
    rw_in     = w;
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    ready_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    step();
    step();
    chk("rst_ready", ready_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_m2r", m2r_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_rw", rw_out, 0);
    rst = 1'b1;
    step();
    chk("rel_ready", ready_out, 1);
    chk("rel_valid", valid_out, 0);

    ready_in = 1'b1;
    drive(1, 32'hAAAA_BBBB, 32'h1111_2222, 1, 5'd10, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("single_valid", valid_out, 1);
    chk("single_result", result_out, 64'hAAAA_BBBB);
    chk("single_rdata", rdata_out, 64'h1111_2222);
    chk("single_m2r", m2r_out, 1);
    chk("single_rd", rd_out, 10);
    chk("single_rw", rw_out, 1);
    step();

    ready_in = 1'b0;
    drive(1, 32'h1, 32'h10, 0, 5'd1, 1);
    step();
    drive(1, 32'h2, 32'h20, 0, 5'd2, 1);
    step();
    drive(1, 32'h3, 32'h30, 0, 5'd3, 1);
    chk("bp_ready_low", ready_out, 0);
    step();
    chk("bp_hold_rd", rd_out, 1);
    chk("bp_hold_ready", ready_out, 0);
    ready_in = 1'b1;
    step();
    chk("bp_order_2", rd_out, 2);
    chk("bp_ready_back", ready_out, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("bp_order_3", rd_out, 3);
    step();
    chk("bp_drained", valid_out, 0);

    ready_in = 1'b0;
    drive(1, 32'h4, 32'h40, 0, 5'd4, 1);
    step();
    drive(1, 32'h5, 32'h50, 0, 5'd5, 1);
    step();
    chk("fl_full", ready_out, 0);
    flush = 1'b1;
    drive(1, 32'h7, 32'h70, 0, 5'd7, 1);
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_valid", valid_out, 0);
    chk("fl_rw", rw_out, 0);
    chk("fl_ready", ready_out, 1);
    ready_in = 1'b1;
    step();
    chk("fl_no_rd7", valid_out, 0);

    drive(1, 32'h55, 32'h66, 0, 5'd0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("x0_valid", valid_out, 1);
    chk("x0_rw", rw_out, 0);
`ifdef MEM_WB_FWD_EN
    chk("x0_fwd_valid", fwd_valid, 0);
`endif
    step();

`ifdef MEM_WB_FWD_EN
    drive(1, 32'h0000_1234, 32'hDEAD_BEEF, 0, 5'd9, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("fwd_data_lit", fwd_data, 64'h0000_1234);
    chk("fwd_rd_lit", fwd_rd, 9);
    chk("fwd_valid_lit", fwd_valid, 1);
    step();
`endif

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      ready_in = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, $urandom, $urandom,
            1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom));
      step();
    end
    rst   = 1'b1;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM/WB pipeline register with valid/ready handshake and a two-entry skid buffer.
- Carries ALU result, load data, mem_to_reg, rd and reg_write from MEM to WB.
- Adds stall back-pressure, flush and x0-write suppression.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- DATA_W, 32, width of result and load-data fields.
- REG_ADDR_W, 5, width of the destination register index.
- ZERO_REG_SUPPRESS, 1, when 1 the block forces reg_write low for rd == 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst == 0 resets on the next clk edge).
- flush_in_mem_wb  in  1  discards all held and incoming entries.
- valid_in_mem_wb  in  1  MEM stage presents an entry.
- ready_out_mem_wb  out  1  block can accept an entry this cycle.
- result_in_mem_wb  in  DATA_W  ALU result.
- read_data_in_mem_wb  in  DATA_W  load data.
- mem_to_reg_in_mem_wb  in  1  selects load data for writeback.
- rd_in_mem_wb  in  REG_ADDR_W  destination register.
- reg_write_in_mem_wb  in  1  register write enable.
- valid_out_mem_wb  out  1  output entry valid.
- ready_in_mem_wb  in  1  WB consumes the output entry.
- result_out_mem_wb  out  DATA_W  registered result.
- read_data_out_mem_wb  out  DATA_W  registered load data.
- mem_to_reg_out_mem_wb  out  1  registered select.
- rd_out_mem_wb  out  REG_ADDR_W  registered rd.
- reg_write_out_mem_wb  out  1  valid_out & reg_write & ~(suppress & rd == 0).

Behaviour:
- Storage: main slot (drives outputs) plus skid slot, each with its own valid bit.
- States: EMPTY (no slot valid), ONE (main valid), TWO (main and skid valid).
- Accept: valid_in & ready_out. Consume: valid_out & ready_in.
- ready_out is registered and equals ~skid_valid, so it is 1 in EMPTY and ONE, 0 in TWO.
- EMPTY:
  - accept loads the main slot, next state ONE.
- ONE:
  - accept and consume: main slot reloads, stays ONE.
  - accept only: entry goes to the skid slot, next state TWO.
  - consume only: next state EMPTY.
- TWO:
  - consume moves skid to main, next state ONE.
  - no accept is possible in TWO.
- Latency: 1 cycle from accept to valid_out when WB is ready. Throughput: 1 entry per cycle.
- Ordering: strict FIFO. No entry is dropped or duplicated except by flush.
- Flush:
  - Clears both valid bits on the next edge and drops any same-cycle incoming entry.
  - ready_out is 1 the next cycle. Flush has priority over accept and consume.
- Data fields are not cleared by flush. Only the valid bits are cleared, so reg_write_out is 0.
- Reset (rst == 0 at an edge):
  - All outputs 0, state EMPTY.
  - ready_out is held 0 while rst is low and is 1 on the first edge after release.
  - Reset mid-operation discards all entries.
- rd == 0 with ZERO_REG_SUPPRESS = 1: the entry still flows and valid_out is 1, but reg_write_out is 0.
- Outputs hold stable while valid_out = 1 and ready_in = 0.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- Defined:
  - Adds outputs fwd_valid_mem_wb (1), fwd_rd_mem_wb (REG_ADDR_W) and fwd_data_mem_wb (DATA_W).
  - fwd_data is the combinational mux: mem_to_reg ? read_data : result, taken from the main slot.
  - fwd_valid = reg_write_out_mem_wb.
  - Used by the EX forwarding unit.
- Undefined: these ports are absent. Core behaviour is unchanged.

Decomposition:
- Package mem_wb_pkg holds:
  - a typedef packed struct mem_wb_entry_t with result, read_data, mem_to_reg, rd and reg_write;
  - the state enum {EMPTY, ONE, TWO};
  - default width constants.
- One sub-module, skid_slot: a one-entry register with load and valid that holds a mem_wb_entry_t. It is instantiated twice (main and skid).

Test Plan:
- Reset low 2 cycles, then high:
  - during reset, all outputs 0 and ready_out 0;
  - the cycle after release, ready_out = 1 and valid_out = 0.
- Single entry (result AAAA_BBBB, read_data 1111_2222, mem_to_reg 1, rd 10, reg_write 1) with ready_in = 1:
  - the next cycle shows valid_out 1, identical fields and reg_write_out 1.
- Back-pressure:
  - send 3 entries back-to-back (rd 1, 2, 3) with ready_in = 0;
  - after 2 accepts ready_out = 0 and the third is held off;
  - raise ready_in: rd 1, 2, 3 emerge in order with no loss.
- Flush while in TWO:
  - next cycle valid_out = 0, reg_write_out = 0, ready_out = 1;
  - a simultaneous valid_in entry (rd 7) never appears.
- rd = 0 with reg_write 1:
  - valid_out 1, reg_write_out 0;
  - if MEM_WB_FWD_EN is defined, fwd_valid = 0.
- MEM_WB_FWD_EN defined, entry with mem_to_reg 0 and result 0000_1234:
  - fwd_data = 0000_1234, fwd_rd matches rd, fwd_valid 1.
